if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipeline: owns the PC and fetches from instruction memory over a req/ack handshake.
//  Buffers fetched words in a small queue and feeds the IF/ID register: valid_o drives send_i; inst_o/pc_o drive inst_i/pc_i.
//  Accepts branch redirects from ID and squashes wrong-path work, including an in-flight memory request.
// PARAMETERS
//  DEPTH     2      fetch-queue entries; power of 2, >=2
//  RESET_PC  32'h0  PC after reset; bits [1:0] must be 0
// PORTS
//  clk_i          in   1   clock; all state updates on posedge
//  rst_i          in   1   reset: synchronous, active-high
//  imem_req_o     out  1   fetch request to instruction memory
//  imem_addr_o    out  32  fetch address; stable while imem_req_o=1
//  imem_ack_i     in   1   memory returns imem_data_i this cycle; variable latency >=1 cycle
//  imem_data_i    in   32  instruction word, valid when imem_ack_i=1
//  stall_i        in   1   from hazard detection: IF/ID holds, no pop
//  branch_i       in   1   taken branch/jump resolved in ID: redirect
//  branch_addr_i  in   32  redirect target; bits [1:0] forced to 0
//  valid_o        out  1   queue head valid; drives IF/ID send_i
//  inst_o         out  32  head instruction; 32'b0 (NOP) when !valid_o
//  pc_o           out  32  head PC+4 (ID branch-target base); 0 when !valid_o
//  flush_o        out  1   = branch_i, combinational; drives IF/ID flush_i
// BEHAVIOUR
//  Reset: state=S_IDLE, fetch_pc=RESET_PC, queue empty, imem_req_o=0, valid_o=0, inst_o=0, pc_o=0.
//   Reset wins over every other input in the same cycle, including mid-S_WAIT.
//  FSM (state encodings in if_defs.vh):
//   S_IDLE: if !branch_i && count<DEPTH: raise req, addr=fetch_pc, go S_WAIT. Otherwise stay.
//   S_WAIT: req=1. On ack: push {fetch_pc+4, data}; fetch_pc+=4; go S_IDLE.
//   S_KILL: req=1, waiting out a squashed request. On ack: discard data, go S_IDLE.
//  At most one outstanding request. Issue rule: count + outstanding < DEPTH, so a push never overflows.
//   Push while full is impossible; assert this in simulation.
//  Pop: valid_o && !stall_i && !branch_i. Pop and push in the same cycle are legal; count is unchanged.
//  Latency: ack at cycle N -> entry visible on outputs at N+1. There is no ack->output bypass.
//   Steady state with a 1-cycle memory and no stalls gives one instruction every 2 cycles.
//  Redirect (branch_i=1): queue cleared; fetch_pc <= {branch_addr_i[31:2],2'b00}; no pop that cycle.
//   In S_WAIT without ack: go S_KILL.
//   In S_WAIT with ack the same cycle: data dropped, go S_IDLE.
//   In S_KILL: stay in S_KILL; new target retained.
//   In S_IDLE: no issue that cycle; the next cycle fetches the target.
//  stall_i with branch_i: branch wins (queue cleared).
//  fetch_pc wraps at 2^32 with no flag. All address arithmetic is 32-bit, carry discarded.
//  Queue pointers: log2(DEPTH) bits plus a 1-bit-wider count; full = count==DEPTH.
// STRUCTURE
//  if_defs.vh: S_IDLE/S_WAIT/S_KILL encodings (2-bit), NOP_INST=32'h0, PC_STEP=4.
//  Sub-module fetch_queue: synchronous FIFO of {pc4[31:0], inst[31:0]}, DEPTH entries.
//   Ports: clk_i, rst_i, clear_i, push_i, pop_i, data_i, data_o, empty_o, count_o.
//   clear_i has priority over push_i and pop_i.
//  Top level holds the FSM, fetch_pc, output muxing to NOP, and the overflow assertion.
// TESTING
//  1 Reset, 1-cycle memory: addrs 0,4,8 requested; valid_o rises 1 cycle after first ack; pc_o=4, inst_o=word@0.
//  2 stall_i held 6 cycles, DEPTH=2: req stops at 2 entries; outputs frozen; on release pops in order pc_o=4 then 8.
//  3 branch_i with target 32'h100 while S_WAIT and no ack: flush_o=1, queue empty, ack data dropped, next addr 0x100.
//  4 branch_i on same cycle as ack: data not pushed, S_IDLE, next request addr = target; branch_addr_i=0x103 -> 0x100.
//  5 rst_i asserted mid-S_WAIT, late ack ignored: all outputs 0, next request addr=RESET_PC.
//  6 fetch_pc=32'hFFFFFFFC fetched: pc_o=0; next request addr=0 (wrap).

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF fetch stage.
//   fetch_state_t : fetch FSM states (idle / waiting on memory / waiting out a squashed request)
//   fetch_entry_t : one fetch-queue entry, {PC+4, instruction}
//   NOP_INST      : instruction presented when no fetched word is available
//   PC_STEP       : PC increment per fetched word
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {PC+4, instruction} entries.
//   clk_i   : clock, all updates on posedge
//   rst_i   : synchronous active-high reset, empties the queue
//   clear_i : empties the queue; has priority over push_i and pop_i
//   push_i  : write data_i at the tail
//   pop_i   : drop the head entry (caller guarantees the queue is non-empty)
//   data_i  : entry to push
//   data_o  : head entry (meaningless when empty_o=1)
//   empty_o : queue holds no entries
//   count_o : number of entries held, 0..DEPTH
module fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               data_i,
  output fetch_entry_t               data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W:0]       count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: IF stage of the 5-stage pipeline. Owns the fetch PC, issues
// one instruction-memory request at a time over a req/ack handshake, buffers
// returned words in fetch_queue and presents the head to the IF/ID register.
// Branch redirects from ID clear the queue and squash any in-flight request.
//   clk_i, rst_i          : clock / synchronous active-high reset
//   imem_req_o/addr_o     : fetch request and address (address held while req=1)
//   imem_ack_i/data_i     : memory response, data valid when ack=1
//   stall_i               : hold the head entry (no pop)
//   branch_i/addr_i       : redirect to branch_addr_i (low two bits ignored)
//   valid_o/inst_o/pc_o   : head entry; NOP and 0 when the queue is empty
//   flush_o               : combinational copy of branch_i for the IF/ID flush
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        flush_o
);

  localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_addr_q;
  logic [31:0]       redirect_pc;
  logic              issue;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign redirect_pc = {branch_addr_i[31:2], 2'b00};
  assign flush_o     = branch_i;

  // Requests are only issued from S_IDLE, where nothing is outstanding, so
  // count < DEPTH is the full "count + outstanding < DEPTH" issue rule.
  // The issued address is latched so it stays stable while a squashed request
  // drains in S_KILL even though fetch_pc already holds the redirect target.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issue       = 1'b0;
    push        = 1'b0;
    imem_req_o  = 1'b0;
    imem_addr_o = req_addr_q;

    unique case (state_q)
      S_IDLE: begin
        imem_addr_o = fetch_pc_q;
        if (!branch_i && (q_count < DEPTH_CNT)) begin
          issue      = 1'b1;
          imem_req_o = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          state_d = S_IDLE;
          if (!branch_i) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end else if (branch_i) begin
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_i) begin
      fetch_pc_d = redirect_pc;
    end
    if (rst_i) begin
      imem_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (issue) begin
        req_addr_q <= fetch_pc_q;
      end
    end
  end

  assign push_entry = '{pc4: fetch_pc_q + PC_STEP, inst: imem_data_i};
  assign pop        = !q_empty && !stall_i && !branch_i;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (branch_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign valid_o = !q_empty;
  assign inst_o  = q_empty ? NOP_INST : head.inst;
  assign pc_o    = q_empty ? '0 : head.pc4;

  assert property (@(posedge clk_i) disable iff (rst_i) !(push && (q_count == DEPTH_CNT)))
    else $error("fetch queue push while full");

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        flush_o;

  int asserts = 0;
  int fails   = 0;

  // Memory model / scoreboard state
  logic [63:0] sb[$];
  logic        mon_en    = 1'b0;
  logic        busy      = 1'b0;
  logic        killed    = 1'b0;
  logic        next_ack  = 1'b0;
  logic        mem_hold  = 1'b0;
  logic        stray_ack = 1'b0;
  int          mem_lat   = 1;
  int          age       = 0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] exp_addr  = RESET_PC;

  always #5 clk_i = ~clk_i;

  if_fetch_stage #(
    .DEPTH    (2),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .valid_o       (valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .flush_o       (flush_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory response driver
  initial begin
    imem_ack_i  = 1'b0;
    imem_data_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #2;
      imem_ack_i  = next_ack || stray_ack;
      imem_data_i = next_ack ? mem_word(req_addr) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: output checks against scoreboard, request tracking, push of expected entries
  initial begin
    logic [63:0] exp_e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        asserts++;
        if (valid_o !== (sb.size() != 0)) begin
          fails++;
          $display("FAIL mon_valid: valid_o=%b expected %b", valid_o, (sb.size() != 0));
        end
        asserts++;
        if (flush_o !== branch_i) begin
          fails++;
          $display("FAIL mon_flush: flush_o=%b expected %b", flush_o, branch_i);
        end
        if (valid_o !== 1'b1) begin
          asserts++;
          if (inst_o !== 32'h0 || pc_o !== 32'h0) begin
            fails++;
            $display("FAIL mon_nop: inst_o=%h pc_o=%h expected 0 0", inst_o, pc_o);
          end
        end else if (!stall_i && !branch_i) begin
          asserts++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL mon_pop: popped pc_o=%h inst_o=%h with no entry expected", pc_o, inst_o);
          end else begin
            exp_e = sb.pop_front();
            if ({pc_o, inst_o} !== exp_e) begin
              fails++;
              $display("FAIL mon_pop: pc_o=%h inst_o=%h expected %h %h",
                       pc_o, inst_o, exp_e[63:32], exp_e[31:0]);
            end
          end
        end

        if (rst_i) begin
          sb.delete();
          busy     = 1'b0;
          killed   = 1'b0;
          exp_addr = RESET_PC;
          next_ack = 1'b0;
        end else begin
          if (branch_i) begin
            sb.delete();
            exp_addr = {branch_addr_i[31:2], 2'b00};
            if (busy) killed = 1'b1;
          end
          if (imem_ack_i && busy) begin
            if (!killed) begin
              sb.push_back({exp_addr + 32'd4, mem_word(exp_addr)});
              exp_addr = exp_addr + 32'd4;
            end
            busy = 1'b0;
          end else if (imem_req_o === 1'b1 && !busy) begin
            asserts++;
            if (imem_addr_o !== exp_addr) begin
              fails++;
              $display("FAIL mon_issue_addr: imem_addr_o=%h expected %h", imem_addr_o, exp_addr);
            end
            busy     = 1'b1;
            killed   = 1'b0;
            age      = 0;
            req_addr = imem_addr_o;
          end else if (busy) begin
            asserts++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== req_addr) begin
              fails++;
              $display("FAIL mon_req_hold: req=%b addr=%h expected 1 %h", imem_req_o, imem_addr_o, req_addr);
            end
            age++;
          end
          next_ack = busy && !mem_hold && (age + 1 >= mem_lat);
        end
      end
    end
  end

  task automatic apply_reset();
    rst_i     = 1'b1;
    stall_i   = 1'b0;
    branch_i  = 1'b0;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: valid_o=%b expected 0", valid_o); end
    asserts++;
    if (inst_o !== 32'h0) begin fails++; $display("FAIL reset_inst: inst_o=%h expected 0", inst_o); end
    asserts++;
    if (pc_o !== 32'h0) begin fails++; $display("FAIL reset_pc: pc_o=%h expected 0", pc_o); end
    asserts++;
    if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: imem_req_o=%b expected 0", imem_req_o); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_basic_fetch();
    int acks;
    bit seen;
    mem_lat = 1;
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      if (imem_ack_i) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen) begin fails++; $display("FAIL basic_first_ack: no ack within 10 cycles, expected one"); end
    asserts++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL basic_no_bypass: valid_o=%b expected 0", valid_o); end
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b1 || pc_o !== 32'd4 || inst_o !== mem_word(32'h0)) begin
      fails++;
      $display("FAIL basic_first_out: valid=%b pc_o=%h inst_o=%h expected 1 00000004 %h",
               valid_o, pc_o, inst_o, mem_word(32'h0));
    end
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (imem_ack_i) acks++;
    end
    asserts++;
    if (acks != 10) begin fails++; $display("FAIL basic_throughput: acks=%0d expected 10", acks); end
  endtask

  task automatic test_stall();
    int acks;
    mem_lat = 1;
    apply_reset();
    stall_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1;
      if (imem_ack_i) acks++;
      if (valid_o) begin
        asserts++;
        if (pc_o !== 32'd4) begin fails++; $display("FAIL stall_frozen: pc_o=%h expected 00000004", pc_o); end
      end
    end
    asserts++;
    if (acks != 2) begin fails++; $display("FAIL stall_acks: acks=%0d expected 2", acks); end
    asserts++;
    if (imem_req_o !== 1'b0) begin fails++; $display("FAIL stall_req_stop: imem_req_o=%b expected 0", imem_req_o); end
    @(posedge clk_i);
    #1;
    stall_i = 1'b0;
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b1 || pc_o !== 32'd4) begin fails++; $display("FAIL stall_pop1: valid=%b pc_o=%h expected 1 00000004", valid_o, pc_o); end
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b1 || pc_o !== 32'd8) begin fails++; $display("FAIL stall_pop2: valid=%b pc_o=%h expected 1 00000008", valid_o, pc_o); end
  endtask

  task automatic test_branch_wait();
    bit seen;
    mem_lat  = 1;
    mem_hold = 1'b1;
    apply_reset();
    @(negedge clk_i);
    #1;
    asserts++;
    if (imem_req_o !== 1'b1) begin fails++; $display("FAIL bw_issue: imem_req_o=%b expected 1", imem_req_o); end
    @(posedge clk_i);
    #1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h100;
    @(negedge clk_i);
    #1;
    asserts++;
    if (flush_o !== 1'b1) begin fails++; $display("FAIL bw_flush: flush_o=%b expected 1", flush_o); end
    @(posedge clk_i);
    #1;
    branch_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL bw_kill_hold: valid=%b req=%b addr=%h expected 0 1 00000000", valid_o, imem_req_o, imem_addr_o);
    end
    @(posedge clk_i);
    #1;
    mem_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      if (imem_ack_i) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen) begin fails++; $display("FAIL bw_ack_timeout: no ack within 10 cycles, expected one"); end
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      fails++;
      $display("FAIL bw_drop: valid=%b req=%b addr=%h expected 0 1 00000100", valid_o, imem_req_o, imem_addr_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (valid_o) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen || pc_o !== 32'h104 || inst_o !== mem_word(32'h100)) begin
      fails++;
      $display("FAIL bw_target: seen=%b pc_o=%h inst_o=%h expected 1 00000104 %h", seen, pc_o, inst_o, mem_word(32'h100));
    end
  endtask

  task automatic test_branch_on_ack();
    bit seen;
    mem_lat = 3;
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      if (next_ack) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen) begin fails++; $display("FAIL ba_setup: response not scheduled within 10 cycles"); end
    @(posedge clk_i);
    #1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h103;
    @(negedge clk_i);
    #1;
    asserts++;
    if (flush_o !== 1'b1 || imem_ack_i !== 1'b1) begin
      fails++;
      $display("FAIL ba_same_cycle: flush_o=%b ack=%b expected 1 1", flush_o, imem_ack_i);
    end
    @(posedge clk_i);
    #1;
    branch_i = 1'b0;
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      fails++;
      $display("FAIL ba_redirect: valid=%b req=%b addr=%h expected 0 1 00000100", valid_o, imem_req_o, imem_addr_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (valid_o) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen || pc_o !== 32'h104 || inst_o !== mem_word(32'h100)) begin
      fails++;
      $display("FAIL ba_target: seen=%b pc_o=%h inst_o=%h expected 1 00000104 %h", seen, pc_o, inst_o, mem_word(32'h100));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    mem_lat = 1;
    apply_reset();
    repeat (5) @(posedge clk_i);
    #1;
    mem_hold = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      if (busy && !next_ack) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen) begin fails++; $display("FAIL rw_setup: no held request within 10 cycles"); end
    @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    stray_ack = 1'b1;
    @(negedge clk_i);
    #1;
    asserts++;
    if (imem_req_o !== 1'b0) begin fails++; $display("FAIL rw_req_in_reset: imem_req_o=%b expected 0", imem_req_o); end
    @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk_i);
    #1;
    asserts++;
    if (valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0) begin
      fails++;
      $display("FAIL rw_outputs: valid=%b inst_o=%h pc_o=%h expected 0 0 0", valid_o, inst_o, pc_o);
    end
    asserts++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      fails++;
      $display("FAIL rw_restart: req=%b addr=%h expected 1 %h", imem_req_o, imem_addr_o, RESET_PC);
    end
    @(posedge clk_i);
    #1;
    stray_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (valid_o) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen || pc_o !== RESET_PC + 32'd4 || inst_o !== mem_word(RESET_PC)) begin
      fails++;
      $display("FAIL rw_first: seen=%b pc_o=%h inst_o=%h expected 1 %h %h", seen, pc_o, inst_o, RESET_PC + 32'd4, mem_word(RESET_PC));
    end
  endtask

  task automatic test_wrap();
    bit seen;
    mem_lat = 1;
    apply_reset();
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFFC;
    @(negedge clk_i);
    #1;
    asserts++;
    if (imem_req_o !== 1'b0) begin fails++; $display("FAIL wrap_idle_redirect: imem_req_o=%b expected 0", imem_req_o); end
    @(posedge clk_i);
    #1;
    branch_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (valid_o) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen || pc_o !== 32'h0 || inst_o !== mem_word(32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL wrap_last: seen=%b pc_o=%h inst_o=%h expected 1 00000000 %h", seen, pc_o, inst_o, mem_word(32'hFFFF_FFFC));
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (valid_o) begin seen = 1'b1; break; end
    end
    asserts++;
    if (!seen || pc_o !== 32'h4 || inst_o !== mem_word(32'h0)) begin
      fails++;
      $display("FAIL wrap_next: seen=%b pc_o=%h inst_o=%h expected 1 00000004 %h", seen, pc_o, inst_o, mem_word(32'h0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_branch_wait();
    test_branch_on_ack();
    test_reset_mid_wait();
    test_wrap();
    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
